// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared IF-stage bus defines and PC helper
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`define ZeroInst 32'h0000_0000
`define ChipEnable 1'b1
`define ChipDisable 1'b0
`define RstEnable 1'b0
`endif

package inst_fetch_pkg;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Natural 32-bit wrap: 32'hFFFF_FFFC advances to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - DEPTH-entry instruction buffer with flush and occupancy count
module inst_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // When full with a pop, wr_ptr == rd_ptr and the slot being overwritten is the one leaving.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF-stage PC generator and instruction buffer
// Optional misaligned-fetch flag per entry: INST_FETCH_MISALIGN_CHK_EN
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rom_ce_o,
  output logic [`InstAddrBus] rom_addr_o,
  input  logic [`InstBus]     rom_inst_i,
  input  logic                jump_flag_i,
  input  logic [`InstAddrBus] jump_addr_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [`InstBus]     inst_o,
  output logic [`InstAddrBus] inst_addr_o
`ifdef INST_FETCH_MISALIGN_CHK_EN
  ,
  output logic                inst_misalign_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef INST_FETCH_MISALIGN_CHK_EN
  localparam int EW = 65;
`else
  localparam int EW = 64;
`endif

  logic [31:0]   pc;
  logic          run;
  logic          fetch;
  logic          pop;
  logic          not_empty;
  logic [CW-1:0] count;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign not_empty  = (count != '0);
  assign id_valid_o = not_empty & ~jump_flag_i;
  assign pop        = id_valid_o & id_ready_i;
  assign fetch      = run & ~jump_flag_i & ((count != FULL_CNT) | pop);
  assign rom_ce_o   = fetch ? `ChipEnable : `ChipDisable;
  assign rom_addr_o = pc;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  assign wdata           = {pc, rom_inst_i, (pc[1:0] != 2'b00)};
  assign inst_misalign_o = not_empty & rdata[0];
  assign inst_addr_o     = not_empty ? rdata[64:33] : 32'h0;
  assign inst_o          = not_empty ? rdata[32:1]  : `ZeroInst;
`else
  assign wdata       = {pc, rom_inst_i};
  assign inst_addr_o = not_empty ? rdata[63:32] : 32'h0;
  assign inst_o      = not_empty ? rdata[31:0]  : `ZeroInst;
`endif

  // run delays the first fetch by one cycle so the ROM sees a clean start.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      pc  <= RESET_ADDR;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (jump_flag_i) pc <= jump_addr_i;
      else if (fetch)  pc <= next_pc(pc);
    end
  end

  inst_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag_i),
    .push  (fetch),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count)
  );
endmodule
